// File: rtl/strobe_stretch.sv
// Stretches one-cycle strobes into HOLD-high / GAP-low LED blinks, one blink per strobe.
// Define STROBE_STRETCH_QUEUE_EN to queue strobes that arrive mid-blink and replay them.
module strobe_stretch #(
    parameter int unsigned HOLD   = 50_000_000,
    parameter int unsigned GAP    = 12_500_000,
    parameter int unsigned CNT_W  = 26,
    parameter int unsigned PEND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic              clr,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GapLoad  = CNT_W'(GAP - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               cnt_zero;
    logic               event_avail;
    logic               start;
    logic               queue_strobe;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (event_avail) begin
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                    start   = 1'b1;
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (event_avail) begin
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                    start   = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A strobe on a starting edge is consumed by that blink; any other strobe must queue.
    assign queue_strobe = strobe && !start;

`ifdef STROBE_STRETCH_QUEUE_EN
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              take_pend;

    assign event_avail = strobe || (pend_q != '0);
    assign take_pend   = start && !strobe;

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (clr) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (queue_strobe && !take_pend) begin
            if (&pend_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (take_pend && !queue_strobe) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;
`else
    assign event_avail = strobe;

    always_comb begin
        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end else if (queue_strobe) begin
            ovf_d = 1'b1;
        end
    end

    assign pending = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign led      = (state_q == StHold);
    assign busy     = (state_q != StIdle);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_strobe_stretch.sv
// Self-checking bench for strobe_stretch: blink-timeline model, directed scenarios, random strobes.
module tb_strobe_stretch;

    localparam int HOLD   = 4;
    localparam int GAP    = 2;
    localparam int CNT_W  = 8;
    localparam int PEND_W = 2;
`ifdef STROBE_STRETCH_QUEUE_EN
    localparam int PMAX = (1 << PEND_W) - 1;
`else
    localparam int PMAX = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              strobe = 1'b0;
    logic              clr = 1'b0;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    strobe_stretch #(
        .HOLD   (HOLD),
        .GAP    (GAP),
        .CNT_W  (CNT_W),
        .PEND_W (PEND_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .strobe   (strobe),
        .clr      (clr),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Model: a blink is a timeline position t in 0..HOLD+GAP-1; led is high while t < HOLD.
    typedef struct {
        bit act;
        int t;
        int p;
        bit o;
    } mstate_t;

    mstate_t m = '{act: 1'b0, t: 0, p: 0, o: 1'b0};

    function automatic mstate_t model_next(input mstate_t s, input bit stb, input bit c);
        mstate_t n = s;
        bit took = 1'b0;
        if (s.act && s.t < HOLD + GAP - 1) begin
            n.t = s.t + 1;
        end else if (stb) begin
            n.act = 1'b1; n.t = 0; took = 1'b1;
        end else if (s.p > 0) begin
            n.act = 1'b1; n.t = 0; n.p = s.p - 1;
        end else begin
            n.act = 1'b0; n.t = 0;
        end
        if (c) begin
            n.p = 0; n.o = 1'b0;
        end else if (stb && !took) begin
            if (n.p < PMAX) n.p = n.p + 1;
            else n.o = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{act: 1'b0, t: 0, p: 0, o: 1'b0};
        else        m <= model_next(m, strobe, clr);
    end

    function automatic int m_led();
        return (m.act && m.t < HOLD) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input int dut_v, input int mdl_v, input int exp_v);
        chk({nm, " dut"}, dut_v, exp_v);
        chk({nm, " model"}, mdl_v, exp_v);
    endtask

    always @(negedge clk) begin
        if (chk_en && reset) begin
            chk("led", int'(led), m_led());
            chk("busy", int'(busy), int'(m.act));
            chk("pending", int'(pending), m.p);
            chk("overflow", int'(overflow), int'(m.o));
        end
    end

    task automatic step(input bit s, input bit c);
        strobe = s;
        clr    = c;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    int rises_dut, rises_mdl, dens;
    bit prev_dut, prev_mdl;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        lit("reset led", int'(led), m_led(), 0);
        lit("reset busy", int'(busy), int'(m.act), 0);
        lit("reset pending", int'(pending), m.p, 0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Three strobes back to back
        for (int i = 0; i < 15; i++) begin
            step(i < 3, 1'b0);
`ifdef STROBE_STRETCH_QUEUE_EN
            if (i == 1)  lit("B pend@1", int'(pending), m.p, 1);
            if (i == 2)  lit("B pend@2", int'(pending), m.p, 2);
            if (i == 5)  lit("B led@5", int'(led), m_led(), 0);
            if (i == 6)  lit("B led@6", int'(led), m_led(), 1);
            if (i == 6)  lit("B pend@6", int'(pending), m.p, 1);
            if (i == 12) lit("B led@12", int'(led), m_led(), 1);
            if (i == 12) lit("B pend@12", int'(pending), m.p, 0);
            if (i == 12) lit("B ovf@12", int'(overflow), int'(m.o), 0);
`else
            if (i == 1) lit("B ovf@1", int'(overflow), int'(m.o), 1);
            if (i == 2) lit("B pend@2", int'(pending), m.p, 0);
            if (i == 6) lit("B led@6", int'(led), m_led(), 0);
            if (i == 6) lit("B busy@6", int'(busy), int'(m.act), 0);
`endif
        end
        idle(10);
        step(1'b0, 1'b1);
        lit("B ovf clr", int'(overflow), int'(m.o), 0);

        // Five strobes: the queue saturates and the last one is dropped
        rises_dut = 0; rises_mdl = 0; prev_dut = 1'b0; prev_mdl = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(i < 5, 1'b0);
            if (led && !prev_dut) rises_dut++;
            if (m_led() == 1 && !prev_mdl) rises_mdl++;
            prev_dut = led;
            prev_mdl = (m_led() == 1);
`ifdef STROBE_STRETCH_QUEUE_EN
            if (i == 3) lit("C pend@3", int'(pending), m.p, 3);
            if (i == 4) lit("C ovf@4", int'(overflow), int'(m.o), 1);
`endif
        end
        lit("C blinks", rises_dut, rises_mdl, PMAX + 1);
        lit("C ovf sticky", int'(overflow), int'(m.o), 1);
        step(1'b0, 1'b1);

        // Strobe on the GAP terminal edge
        for (int i = 0; i < 20; i++) begin
            step(i == 0 || i == 1 || i == 6, 1'b0);
            if (i == 5) lit("D led@5", int'(led), m_led(), 0);
            if (i == 6) lit("D led@6", int'(led), m_led(), 1);
            if (i == 6) lit("D pend@6", int'(pending), m.p, PMAX > 0 ? 1 : 0);
        end
        idle(10);
        step(1'b0, 1'b1);

        // clr while a replayed blink is in HOLD
        for (int i = 0; i < 14; i++) begin
            step(i < 5, i == 7);
`ifdef STROBE_STRETCH_QUEUE_EN
            if (i == 6)  lit("E pend@6", int'(pending), m.p, 2);
            if (i == 6)  lit("E ovf@6", int'(overflow), int'(m.o), 1);
            if (i == 7)  lit("E pend@7", int'(pending), m.p, 0);
            if (i == 7)  lit("E led@7", int'(led), m_led(), 1);
            if (i == 10) lit("E led@10", int'(led), m_led(), 0);
            if (i == 12) lit("E busy@12", int'(busy), int'(m.act), 0);
`else
            if (i == 6) lit("E busy@6", int'(busy), int'(m.act), 0);
`endif
            if (i == 7) lit("E ovf@7", int'(overflow), int'(m.o), 0);
        end
        idle(4);

        // Asynchronous reset in the middle of HOLD
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        lit("R led", int'(led), m_led(), 0);
        lit("R busy", int'(busy), int'(m.act), 0);
        lit("R pending", int'(pending), m.p, 0);
        lit("R overflow", int'(overflow), int'(m.o), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single isolated strobe after reset release
        for (int i = 0; i < 8; i++) begin
            step(i == 0, 1'b0);
            lit($sformatf("A led@%0d", i), int'(led), m_led(), i < HOLD ? 1 : 0);
            lit($sformatf("A busy@%0d", i), int'(busy), int'(m.act), i < HOLD + GAP ? 1 : 0);
        end

        // Random strobes at varying density with occasional clr
        for (int blk = 0; blk < 8; blk++) begin
            case ($urandom_range(0, 3))
                0: dens = 3;
                1: dens = 12;
                2: dens = 30;
                default: dens = 60;
            endcase
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 99) < dens, $urandom_range(0, 59) == 0);
            end
        end
        idle(3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
